// File: rtl/piso_serializer.sv
// ============================================================================
// piso_serializer : valid/ready word in, LSB-first serial bits out on SDR
// Revision 1.0
// ============================================================================
`default_nettype none

module piso_serializer #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_CYCLES   = 0
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             SDR,
  output logic             bit_strobe,
  output logic             frame_end,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(CLKS_PER_BIT + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic          ONE_CLK  = (CLKS_PER_BIT == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BW-1:0]    bitcnt_q;
  logic [DW-1:0]    divcnt_q;
  logic [GW-1:0]    gapcnt_q;
  logic             strobe_q;
  logic             fend_q;
  logic             busy_q;

  logic [DW-1:0]    divcnt_d;
  logic [BW-1:0]    bitcnt_d;

  assign divcnt_d = divcnt_q + 1'b1;
  assign bitcnt_d = bitcnt_q + 1'b1;

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      gapcnt_q <= '0;
      strobe_q <= 1'b0;
      fend_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      fend_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            shreg_q  <= din;
            bitcnt_q <= '0;
            divcnt_q <= '0;
            busy_q   <= 1'b1;
            strobe_q <= ONE_CLK;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          // Strobes are registered, so they are raised one edge ahead of
          // the cycle in which the divider reaches terminal count.
          if (divcnt_q == DIV_LAST) begin
            divcnt_q <= '0;
            shreg_q  <= {1'b0, shreg_q[WIDTH-1:1]};
            bitcnt_q <= bitcnt_d;
            if (bitcnt_q == BIT_LAST) begin
              if (GAP_CYCLES > 0) begin
                gapcnt_q <= '0;
                state_q  <= GAP;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              strobe_q <= ONE_CLK;
              fend_q   <= ONE_CLK && (bitcnt_d == BIT_LAST);
            end
          end else begin
            divcnt_q <= divcnt_d;
            strobe_q <= (divcnt_d == DIV_LAST);
            fend_q   <= (divcnt_d == DIV_LAST) && (bitcnt_q == BIT_LAST);
          end
        end
        GAP: begin
          if (gapcnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gapcnt_q <= gapcnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The shift register drains to all zeros by the end of each frame,
  // which gives the idle level on SDR without a separate output mux.
  assign SDR        = shreg_q[0];
  assign bit_strobe = strobe_q;
  assign frame_end  = fend_q;
  assign busy       = busy_q;
  assign din_ready  = (state_q == IDLE) & clrb;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// tb_piso_serializer : directed checks of piso_serializer at three parameter sets
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_piso_serializer;

  logic clk;
  logic clrb;

  logic [3:0] din_a, din_b, din_c;
  logic vld_a, vld_b, vld_c;
  logic rdy_a, rdy_b, rdy_c;
  logic sdr_a, sdr_b, sdr_c;
  logic stb_a, stb_b, stb_c;
  logic fe_a, fe_b, fe_c;
  logic busy_a, busy_b, busy_c;

  logic [3:0] rx_q;

  int n_checks = 0;
  int n_fail   = 0;

  piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(1), .GAP_CYCLES(0)) u_dut_a (
    .clk(clk), .clrb(clrb), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .SDR(sdr_a), .bit_strobe(stb_a), .frame_end(fe_a), .busy(busy_a)
  );

  piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(3), .GAP_CYCLES(0)) u_dut_b (
    .clk(clk), .clrb(clrb), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .SDR(sdr_b), .bit_strobe(stb_b), .frame_end(fe_b), .busy(busy_b)
  );

  piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(1), .GAP_CYCLES(2)) u_dut_c (
    .clk(clk), .clrb(clrb), .din(din_c), .din_valid(vld_c), .din_ready(rdy_c),
    .SDR(sdr_c), .bit_strobe(stb_c), .frame_end(fe_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-bit right-shift receiver, shifting only on bit strobes.
  always @(posedge clk or negedge clrb) begin
    if (!clrb) rx_q <= 4'b0000;
    else if (stb_a) rx_q <= {sdr_a, rx_q[3:1]};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input logic r, input logic b, input logic f,
                                     input logic s, input logic d);
    return {27'b0, r, b, f, s, d};
  endfunction

  initial begin
    logic [4:0]  e5_sdr, e5_stb, e5_fe, e5_busy, e5_rdy;
    logic [11:0] e12_sdr, e12_stb, e12_fe;
    logic [7:0]  e8_sdr, e8_stb, e8_fe, e8_busy, e8_rdy;
    int          n;

    clrb  = 1'b0;
    din_a = 4'h0; din_b = 4'h0; din_c = 4'h0;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;

    // Reset held for three cycles with din_valid toggling.
    for (int i = 0; i < 3; i++) begin
      tick();
      vld_a = ~vld_a; vld_b = ~vld_b; vld_c = ~vld_c;
      din_a = 4'hF; din_b = 4'hF; din_c = 4'hF;
      check_eq("rst_a", pk(rdy_a, busy_a, fe_a, stb_a, sdr_a), 32'h0);
      check_eq("rst_b", pk(rdy_b, busy_b, fe_b, stb_b, sdr_b), 32'h0);
      check_eq("rst_c", pk(rdy_c, busy_c, fe_c, stb_c, sdr_c), 32'h0);
    end
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
    clrb = 1'b1;
    #1;
    check_eq("rel_rdy_a", 32'(rdy_a), 32'h1);
    check_eq("rel_rdy_b", 32'(rdy_b), 32'h1);
    check_eq("rel_rdy_c", 32'(rdy_c), 32'h1);
    tick();

    // Basic frame, 4'b1011 at one clock per bit.
    e5_sdr = 5'b11010; e5_stb = 5'b11110; e5_fe = 5'b00010;
    e5_busy = 5'b11110; e5_rdy = 5'b00001;
    din_a = 4'b1011; vld_a = 1'b1;
    tick();
    vld_a = 1'b0; din_a = 4'b0000;
    for (int j = 1; j <= 5; j++) begin
      check_eq("basic_sdr",  32'(sdr_a),  32'(e5_sdr[5-j]));
      check_eq("basic_stb",  32'(stb_a),  32'(e5_stb[5-j]));
      check_eq("basic_fe",   32'(fe_a),   32'(e5_fe[5-j]));
      check_eq("basic_busy", 32'(busy_a), 32'(e5_busy[5-j]));
      check_eq("basic_rdy",  32'(rdy_a),  32'(e5_rdy[5-j]));
      tick();
    end
    check_eq("basic_rx", 32'(rx_q), 32'hB);

    // Divided rate, 4'b0110 at three clocks per bit.
    e12_sdr = 12'b000111111000;
    e12_stb = 12'b001001001001;
    e12_fe  = 12'b000000000001;
    din_b = 4'b0110; vld_b = 1'b1;
    tick();
    vld_b = 1'b0; din_b = 4'b1001;
    for (int j = 1; j <= 12; j++) begin
      check_eq("div_sdr", 32'(sdr_b), 32'(e12_sdr[12-j]));
      check_eq("div_stb", 32'(stb_b), 32'(e12_stb[12-j]));
      check_eq("div_fe",  32'(fe_b),  32'(e12_fe[12-j]));
      tick();
    end
    check_eq("div_end", pk(rdy_b, busy_b, fe_b, stb_b, sdr_b), 32'h10);

    // Gap of two cycles with din_valid held high on new data.
    e8_sdr  = 8'b11110000;
    e8_stb  = 8'b11110001;
    e8_fe   = 8'b00010000;
    e8_busy = 8'b11111101;
    e8_rdy  = 8'b00000010;
    din_c = 4'b1111; vld_c = 1'b1;
    tick();
    din_c = 4'b0000;
    for (int j = 1; j <= 8; j++) begin
      check_eq("gap_sdr",  32'(sdr_c),  32'(e8_sdr[8-j]));
      check_eq("gap_stb",  32'(stb_c),  32'(e8_stb[8-j]));
      check_eq("gap_fe",   32'(fe_c),   32'(e8_fe[8-j]));
      check_eq("gap_busy", 32'(busy_c), 32'(e8_busy[8-j]));
      check_eq("gap_rdy",  32'(rdy_c),  32'(e8_rdy[8-j]));
      tick();
    end
    vld_c = 1'b0;
    n = 0;
    while (!rdy_c && n < 20) begin
      tick();
      n++;
    end
    check_eq("gap_drain_rdy", 32'(rdy_c), 32'h1);

    // Mid-frame asynchronous reset during bit 2 of 4'b1010.
    din_a = 4'b1010; vld_a = 1'b1;
    tick();
    vld_a = 1'b0;
    tick();
    tick();
    check_eq("mid_bit2_sdr", 32'(sdr_a), 32'h0);
    check_eq("mid_bit2_busy", 32'(busy_a), 32'h1);
    #2;
    clrb = 1'b0;
    #1;
    check_eq("mid_async", pk(rdy_a, busy_a, fe_a, stb_a, sdr_a), 32'h0);
    for (int j = 0; j < 2; j++) begin
      tick();
      check_eq("mid_held", pk(rdy_a, busy_a, fe_a, stb_a, sdr_a), 32'h0);
    end
    clrb = 1'b1;
    #1;
    check_eq("mid_rel_rdy", 32'(rdy_a), 32'h1);
    for (int j = 0; j < 4; j++) begin
      tick();
      check_eq("mid_no_fe", pk(rdy_a, busy_a, fe_a, stb_a, sdr_a), 32'h10);
    end
    e5_sdr = 5'b10100; e5_fe = 5'b00010;
    din_a = 4'b0101; vld_a = 1'b1;
    tick();
    vld_a = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      check_eq("fresh_sdr", 32'(sdr_a), 32'(e5_sdr[5-j]));
      check_eq("fresh_fe",  32'(fe_a),  32'(e5_fe[5-j]));
      tick();
    end
    check_eq("fresh_rx", 32'(rx_q), 32'h5);

    // Back-to-back accepts with din_valid held high.
    check_eq("b2b_rdy0", 32'(rdy_a), 32'h1);
    e5_sdr = 5'b10010; e5_rdy = 5'b00001;
    din_a = 4'b1001; vld_a = 1'b1;
    tick();
    for (int j = 1; j <= 15; j++) begin
      check_eq("b2b_sdr", 32'(sdr_a), 32'(e5_sdr[4 - ((j - 1) % 5)]));
      check_eq("b2b_rdy", 32'(rdy_a), 32'(e5_rdy[4 - ((j - 1) % 5)]));
      tick();
    end
    vld_a = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    check_eq("b2b_idle", pk(rdy_a, busy_a, fe_a, stb_a, sdr_a), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that feeds the team's 4-bit right-shift register stage through its serial-data input (SDR). It accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB-first, one bit per bit period. After WIDTH bit strobes, a downstream right-shift register holds the original word with bit 0 in Q[0]. A per-bit strobe and an end-of-frame pulse let downstream logic gate shifting and capture the result.

## Interface
- WIDTH, 4: word width in bits; must be ≥ 2.
- CLKS_PER_BIT, 1: clock cycles each bit is held on SDR; must be ≥ 1.
- GAP_CYCLES, 0: idle cycles forced after each frame before the next word is accepted; must be ≥ 0.

- clk  in  1  single clock; all state updates on the rising edge.
- clrb  in  1  asynchronous, active-low reset.
- din  in  WIDTH  parallel word to transmit.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  block can accept a word; equals (state==IDLE) & clrb.
- SDR  out  1  serial data, LSB first; driven directly from a register bit.
- bit_strobe  out  1  registered one-cycle pulse in the last cycle of each bit period.
- frame_end  out  1  registered one-cycle pulse coincident with the final bit_strobe of a frame.
- busy  out  1  high in SHIFT and GAP.

## Operation
- **Reset (clrb low, asynchronous):**
  - state=IDLE; shift register, bit counter and divider counter cleared to 0.
  - SDR=0, bit_strobe=0, frame_end=0, busy=0, din_ready=0.
- **IDLE:**
  - SDR=0 (idle level), din_ready=1.
  - On din_valid & din_ready at a rising edge: load din into the shift register, clear the bit and divider counters, go to SHIFT.
- **SHIFT:**
  - SDR = shreg[0].
  - The divider counts 0..CLKS_PER_BIT-1. At terminal count the block pulses bit_strobe, shifts shreg right with 0 filled into the MSB, increments the bit counter, and clears the divider.
  - When the strobe is for bit WIDTH-1, frame_end pulses too. The next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- **GAP:**
  - SDR=0; counts GAP_CYCLES cycles, then goes to IDLE.
- **Handshake rules:**
  - din_valid outside IDLE is ignored; no capture and no error.
  - din may change freely after acceptance without affecting the frame in flight.
- **Counter widths:**
  - Bit counter is $clog2(WIDTH+1) bits; divider is $clog2(CLKS_PER_BIT+1) bits; gap counter is $clog2(GAP_CYCLES+1) bits, minimum 1.
  - No counter may wrap within a frame.
- **Reset mid-frame:** aborts immediately. No frame_end is produced. After release the block is in IDLE with din_ready=1.
- **Back-to-back frames:** din_ready is low in the final SHIFT cycle, so there is at least one IDLE cycle between frames even with GAP_CYCLES=0.

## Timing
- Handshake accepted at rising edge k:
  - SDR=din[0] during cycles k+1 .. k+CLKS_PER_BIT.
  - Bit i is on SDR during cycles k+1+i·CLKS_PER_BIT .. k+(i+1)·CLKS_PER_BIT.
- bit_strobe for bit i is high in cycle k+(i+1)·CLKS_PER_BIT, the last cycle bit i is stable on SDR.
- frame_end and the last bit_strobe are both high in cycle k+WIDTH·CLKS_PER_BIT.
- busy is high from cycle k+1 through k+WIDTH·CLKS_PER_BIT+GAP_CYCLES.
- din_ready returns to 1 in cycle k+WIDTH·CLKS_PER_BIT+GAP_CYCLES+1.
- Frame length: WIDTH·CLKS_PER_BIT cycles. Minimum accept-to-accept spacing: WIDTH·CLKS_PER_BIT+GAP_CYCLES+1 cycles.
- All outputs except din_ready are registered. din_ready is combinational from state and clrb.

## Test plan
- **Reset values:**
  - Hold clrb=0 for 3 cycles, toggling din_valid -> SDR, bit_strobe, frame_end and busy stay 0, and din_ready=0 throughout.
  - After release -> din_ready=1 in the first cycle.
- **Basic frame (WIDTH=4, CLKS_PER_BIT=1):**
  - Accept din=4'b1011 -> SDR reads 1,1,0,1 in cycles k+1..k+4, and bit_strobe is high in each of those cycles.
  - frame_end is high only in cycle k+4.
  - A bench 4-bit right-shift receiver clocked by clk, with SDR as input, holds Q=4'b1011 after edge k+5.
- **Divided rate (CLKS_PER_BIT=3):**
  - Accept din=4'b0110 -> each bit is held for 3 cycles (SDR = 0,0,0,1,1,1,1,1,1,0,0,0).
  - bit_strobe fires at k+3, k+6, k+9, k+12; frame_end fires at k+12.
- **Ignored input and gap (GAP_CYCLES=2):**
  - Accept 4'b1111, then hold din_valid=1 with din=4'b0000 throughout -> the first frame is unchanged.
  - din_ready=0 until k+7; the second word is accepted at edge k+7 and the first SDR=0 bit appears at k+8.
- **Mid-frame reset:**
  - Pulse clrb low asynchronously during bit 2 of 4'b1010 -> SDR=0 immediately and no frame_end occurs.
  - After release -> din_ready=1, and a fresh 4'b0101 transmits correctly.
- **Back-to-back accepts (GAP_CYCLES=0):**
  - din_valid held high with 4'b1001 -> accepts occur every 5 cycles.
  - SDR shows 1,0,0,1 followed by one 0 idle cycle, repeating.
